pyr_word_packer: RTL and testbench

- Consumes the decimated Gaussian-pyramid pixel stream produced by gauss_buffers (pyr_out / out_valid / odd_out).
- Tracks position within the half-resolution output image and packs 4 pixels per 32-bit word.
- Queues words in a small FIFO and presents them on a valid/ready stream, with frame/line markers, to the pyramid-level memory writer.
- The input side has no backpressure; FIFO overflow is detected and flagged.

---
 rtl/pyr_word_packer_pkg.sv | 18 +
 rtl/pyr_word_packer_if.sv | 13 +
 rtl/pyr_word_fifo.sv | 61 ++++++
 rtl/pyr_word_packer.sv | 108 ++++++++++
 tb/tb_pyr_word_packer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pyr_word_packer_pkg.sv
// Shared constants and the FIFO entry layout for the pyramid word packer.
// Entry bit map: data [31:0], sof 32, eol 33, eof 34.
package pyr_word_packer_pkg;
   localparam int PIX_W    = 8;
   localparam int WORD_PIX = 4;
   localparam int WORD_W   = PIX_W * WORD_PIX;
   localparam int SOF_BIT  = 32;
   localparam int EOL_BIT  = 33;
   localparam int EOF_BIT  = 34;
   localparam int ENTRY_W  = 35;

   typedef struct packed {
      logic              eof;
      logic              eol;
      logic              sof;
      logic [WORD_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/pyr_word_packer_if.sv
// Word stream from the packer to the pyramid-level memory writer.
interface pyr_word_packer_if;
   import pyr_word_packer_pkg::*;
   logic [WORD_W-1:0] data;
   logic              sof;
   logic              eol;
   logic              eof;
   logic              valid;
   logic              ready;

   modport master (output data, sof, eol, eof, valid, input ready);
   modport slave  (input data, sof, eol, eof, valid, output ready);
endinterface

// File: rtl/pyr_word_fifo.sv
// First-word fall-through FIFO; when empty the output holds the last popped entry.
module pyr_word_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 35
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] last_q;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/pyr_word_packer.sv
// Packs the decimated pyramid pixel stream into 32-bit words with frame/line
// markers and queues them for the level memory writer.
module pyr_word_packer
   import pyr_word_packer_pkg::*;
#(
   parameter int COL        = 752,
   parameter int ROW        = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic [PIX_W-1:0]              pix_in,
   input  logic                          pix_valid,
   input  logic                          odd_in,
   pyr_word_packer_if.master             m,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int OUT_COL = COL / 2;
   localparam int OUT_ROW = ROW / 2;
   localparam int CW      = $clog2(OUT_COL);
   localparam int RW      = $clog2(OUT_ROW);

   logic [CW-1:0]           out_col;
   logic [RW-1:0]           out_row;
   logic [1:0]              lane_cnt;
   logic [2:0][PIX_W-1:0]   lanes;
   entry_t                  word_q, head;
   logic                    push_q, fifo_full, fifo_empty, pop;
   logic                    acc, last_col, last_row;

   assign acc      = pix_valid && !odd_in;
   assign last_col = (out_col == CW'(OUT_COL-1));
   assign last_row = (out_row == RW'(OUT_ROW-1));
   assign pop      = !fifo_empty && m.ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_col    <= '0;
         out_row    <= '0;
         lane_cnt   <= '0;
         lanes      <= '0;
         word_q     <= '0;
         push_q     <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else if (clr) begin
         out_col    <= '0;
         out_row    <= '0;
         lane_cnt   <= '0;
         lanes      <= '0;
         word_q     <= '0;
         push_q     <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         push_q     <= 1'b0;
         frame_done <= acc && last_col && last_row;
         if (push_q && fifo_full && !pop) overflow <= 1'b1;
         if (acc) begin
            lane_cnt <= lane_cnt + 2'd1;
            case (lane_cnt)
               2'd0: lanes[0] <= pix_in;
               2'd1: lanes[1] <= pix_in;
               2'd2: lanes[2] <= pix_in;
               default: begin
                  // Flags are taken from the position of the 4th pixel.
                  word_q.data <= {pix_in, lanes[2], lanes[1], lanes[0]};
                  word_q.sof  <= (out_row == '0) && (out_col == CW'(3));
                  word_q.eol  <= last_col;
                  word_q.eof  <= last_col && last_row;
                  push_q      <= 1'b1;
               end
            endcase
            if (last_col) begin
               out_col <= '0;
               out_row <= last_row ? '0 : out_row + 1'b1;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end
      end
   end

   pyr_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push_q),
      .pop   (pop),
      .din   (word_q),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign m.valid = !fifo_empty;
   assign m.data  = head.data;
   assign m.sof   = m.valid && head.sof;
   assign m.eol   = m.valid && head.eol;
   assign m.eof   = m.valid && head.eof;
endmodule

// File: tb/tb_pyr_word_packer.sv
// Directed bench for pyr_word_packer on a reduced 48x12 input (24x6 level, 6 words/line).
module tb_pyr_word_packer;
   localparam int COL = 48, ROW = 12, DEPTH = 16;
   localparam int WPL = COL / 8;            // words per output line
   localparam int WPF = WPL * (ROW / 2);    // words per frame

   logic       clk = 1'b0, rst = 1'b1, clr = 1'b0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0, odd_in = 1'b0;
   logic       frame_done, overflow;
   logic [4:0] fifo_level;
   int         checks = 0, errors = 0;

   int mon_en = 0, wcnt = 0, eol_cnt = 0, eof_cnt = 0, sof_cnt = 0, bad = 0, fd_cnt = 0;

   pyr_word_packer_if m_if ();

   pyr_word_packer #(.COL(COL), .ROW(ROW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clr(clr), .pix_in(pix_in), .pix_valid(pix_valid),
      .odd_in(odd_in), .m(m_if), .frame_done(frame_done), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wexp(input int b);
      return {8'(b+3), 8'(b+2), 8'(b+1), 8'(b)};
   endfunction

   // Word-stream observer for the full-frame run.
   always @(posedge clk) begin
      if (mon_en != 0) begin
         if (frame_done) fd_cnt++;
         if (m_if.valid && m_if.ready) begin
            if (m_if.eol) eol_cnt++;
            if (m_if.eof) eof_cnt++;
            if (m_if.sof) sof_cnt++;
            if (m_if.eol !== ((wcnt % WPL) == WPL-1)) bad++;
            if (m_if.eof !== ((wcnt % WPF) == WPF-1)) bad++;
            if (m_if.sof !== ((wcnt % WPF) == 0)) bad++;
            if (m_if.data !== wexp((wcnt % WPL) * 4)) bad++;
            wcnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] p, input logic odd);
      pix_in = p; pix_valid = 1'b1; odd_in = odd;
      tick();
      pix_valid = 1'b0; odd_in = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      chk({tag, "_valid"}, 64'(m_if.valid), 64'd1);
      chk({tag, "_data"}, 64'(m_if.data), 64'(exp));
      m_if.ready = 1'b1;
      tick();
      m_if.ready = 1'b0;
   endtask

   initial begin
      m_if.ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 64'(m_if.valid), 64'd0);
      chk("rst_data", 64'(m_if.data), 64'd0);
      chk("rst_flags", 64'({m_if.sof, m_if.eol, m_if.eof}), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_fd", 64'(frame_done), 64'd0);
      rst = 1'b0;
      tick();

      // First word of a frame: two-cycle latency, sof set.
      m_if.ready = 1'b1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      chk("lat_early", 64'(m_if.valid), 64'd0);
      tick();
      chk("w0_valid", 64'(m_if.valid), 64'd1);
      chk("w0_data", 64'(m_if.data), 64'h44332211);
      chk("w0_sof", 64'(m_if.sof), 64'd1);
      tick();
      chk("w0_popped", 64'(m_if.valid), 64'd0);
      send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
      tick();
      chk("w1_data", 64'(m_if.data), 64'h88776655);
      chk("w1_sof", 64'(m_if.sof), 64'd0);
      tick();

      // Mid-frame clear with a queued word, a partial word and a pixel on the clr cycle.
      m_if.ready = 1'b0;
      send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
      tick();
      chk("pre_clr_level", 64'(fifo_level), 64'd1);
      send(8'hA1, 0); send(8'hA2, 0);
      pix_in = 8'hFF; pix_valid = 1'b1;
      do_clr();
      pix_valid = 1'b0;
      chk("clr_valid", 64'(m_if.valid), 64'd0);
      chk("clr_data", 64'(m_if.data), 64'd0);
      chk("clr_level", 64'(fifo_level), 64'd0);
      chk("clr_ovf", 64'(overflow), 64'd0);
      m_if.ready = 1'b1;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      tick();
      chk("post_clr_data", 64'(m_if.data), 64'h04030201);
      chk("post_clr_sof", 64'(m_if.sof), 64'd1);
      tick();

      // Odd-phase samples are dropped: 16 samples give 2 words.
      m_if.ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(8'(8'hB1 + i), 0);
         send(8'hEE, 1);
      end
      tick();
      chk("odd_level", 64'(fifo_level), 64'd2);
      pop_chk("odd_w0", 32'hB4B3B2B1);
      pop_chk("odd_w1", 32'hB8B7B6B5);

      // Full frame at one pixel per clock, then the first word of the next frame.
      do_clr();
      m_if.ready = 1'b1;
      mon_en = 1;
      for (int r = 0; r < ROW/2; r++)
         for (int c = 0; c < COL/2; c++)
            send(8'(c), 0);
      for (int c = 0; c < 4; c++) send(8'(c), 0);
      repeat (4) tick();
      mon_en = 0;
      chk("frm_words", 64'(wcnt), 64'(WPF + 1));
      chk("frm_eol", 64'(eol_cnt), 64'(ROW/2));
      chk("frm_eof", 64'(eof_cnt), 64'd1);
      chk("frm_sof", 64'(sof_cnt), 64'd2);
      chk("frm_fields", 64'(bad), 64'd0);
      chk("frm_done", 64'(fd_cnt), 64'd1);
      chk("frm_ovf", 64'(overflow), 64'd0);

      // Backpressure: 17 words into a 16-deep FIFO drops the last one.
      do_clr();
      m_if.ready = 1'b0;
      for (int i = 0; i < 68; i++) send(8'(i), 0);
      tick();
      chk("ovf_level", 64'(fifo_level), 64'd16);
      chk("ovf_set", 64'(overflow), 64'd1);
      for (int w = 0; w < 16; w++) pop_chk("ovf_drain", wexp(w*4));
      chk("ovf_empty", 64'(m_if.valid), 64'd0);
      chk("ovf_sticky", 64'(overflow), 64'd1);
      chk("ovf_hold", 64'(m_if.data), 64'(wexp(60)));

      // Full FIFO with a pop in the push cycle: nothing is lost.
      do_clr();
      for (int i = 0; i < 64; i++) send(8'(i), 0);
      tick();
      chk("fp_full", 64'(fifo_level), 64'd16);
      for (int i = 64; i < 68; i++) send(8'(i), 0);
      m_if.ready = 1'b1;
      tick();
      m_if.ready = 1'b0;
      chk("fp_level", 64'(fifo_level), 64'd16);
      chk("fp_ovf", 64'(overflow), 64'd0);
      for (int w = 1; w < 17; w++) pop_chk("fp_drain", wexp(w*4));
      chk("fp_empty", 64'(fifo_level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
